debug_console: RTL and testbench

Board-level run/step controller and debug-channel viewer for the processor on the DE2 board.
- Debounces two raw pushbuttons (Step, Run), producing a registered one-cycle processor clock-enable in single-step or free-run mode, plus a step counter.
- Selects one of NUM_CH debug words for the HEX display, chosen manually from switches or auto-scrolled through all channels on a timer.

---
 rtl/debug_console_pkg.sv | 17 +
 rtl/debug_console_if.sv | 32 +++
 rtl/debug_console_btn_debounce.sv | 52 +++++
 rtl/debug_console.sv | 146 ++++++++++++++
 tb/tb_debug_console.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/debug_console_pkg.sv
// Shared types and helpers for the debug console: run-state encoding, step counter width,
// and a counter-width helper for the timers.
package debug_console_pkg;

  typedef enum logic {
    HALT = 1'b0,
    RUN  = 1'b1
  } run_state_t;

  localparam int unsigned STEP_CNT_W = 16;

  // Width needed to hold a count of 0..n-1, never less than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debug_console_if.sv
// Button, channel-select and display signals of the debug console, with a board-side
// (master) view and a console-side (slave) view.
interface debug_console_if
  import debug_console_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned NUM_CH = 8
);
  localparam int unsigned CH_W = $clog2(NUM_CH);

  logic                    StepBtn;
  logic                    RunBtn;
  logic                    AutoScroll;
  logic [CH_W-1:0]         ChSel;
  logic [NUM_CH*WIDTH-1:0] ChData;
  logic                    CpuEn;
  logic                    Running;
  logic [STEP_CNT_W-1:0]   StepCount;
  logic [CH_W-1:0]         ShownCh;
  logic [WIDTH-1:0]        ShownData;

  modport master (
    output StepBtn, RunBtn, AutoScroll, ChSel, ChData,
    input  CpuEn, Running, StepCount, ShownCh, ShownData
  );

  modport slave (
    input  StepBtn, RunBtn, AutoScroll, ChSel, ChData,
    output CpuEn, Running, StepCount, ShownCh, ShownData
  );

endinterface

// File: rtl/debug_console_btn_debounce.sv
// Raw pushbutton conditioner: two-flop synchronizer, stability counter, and a registered
// one-cycle pulse on each accepted press.
module btn_debounce
  import debug_console_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Raw,
  output logic Level,
  output logic Press
);

  localparam int unsigned       CNT_W    = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mismatch, flip;

  // A change is accepted only after the synced level disagrees for DEBOUNCE_CYCLES cycles.
  always_comb begin
    mismatch = (sync2_q != stable_q);
    flip     = mismatch && (cnt_q == CNT_LAST);
    cnt_d    = (!mismatch || flip) ? '0 : cnt_q + CNT_W'(1);
    stable_d = stable_q ^ flip;
    press_d  = flip && !stable_q;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= Raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign Level = stable_q;
  assign Press = press_q;

endmodule

// File: rtl/debug_console.sv
// Run/step controller and debug-channel viewer: turns debounced Step/Run presses into a
// processor clock-enable and picks one debug word for the HEX display.
module debug_console
  import debug_console_pkg::*;
#(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned NUM_CH          = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned RUN_PERIOD      = 25000000,
  parameter int unsigned SCROLL_PERIOD   = 50000000
) (
  input logic           Clk,
  input logic           Reset,
  debug_console_if.slave bus
);

  localparam int unsigned       CH_W     = $clog2(NUM_CH);
  localparam int unsigned       RUN_W    = cnt_w(RUN_PERIOD);
  localparam int unsigned       SCR_W    = cnt_w(SCROLL_PERIOD);
  localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(RUN_PERIOD - 1);
  localparam logic [SCR_W-1:0]  SCR_LAST = SCR_W'(SCROLL_PERIOD - 1);
  localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(NUM_CH - 1);

  logic step_press, run_press;
  logic step_level_unused, run_level_unused;

  run_state_t            state_q, state_d;
  logic [RUN_W-1:0]      run_tmr_q, run_tmr_d;
  logic                  cpu_en_q, cpu_en_d;
  logic                  running_q;
  logic [STEP_CNT_W-1:0] step_cnt_q, step_cnt_d;

  logic [SCR_W-1:0]      scr_tmr_q, scr_tmr_d;
  logic                  auto_q;
  logic [CH_W-1:0]       shown_ch_q, shown_ch_d;
  logic [WIDTH-1:0]      shown_data_q, sel_data;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .Clk   (Clk),
    .Reset (Reset),
    .Raw   (bus.StepBtn),
    .Level (step_level_unused),
    .Press (step_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .Clk   (Clk),
    .Reset (Reset),
    .Raw   (bus.RunBtn),
    .Level (run_level_unused),
    .Press (run_press)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= HALT;
    else       state_q <= state_d;
  end

  // Run press toggles between HALT and RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HALT:    if (run_press) state_d = RUN;
      RUN:     if (run_press) state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  // Run press takes priority over a coincident step press; leaving RUN drops the timer.
  always_comb begin
    cpu_en_d  = 1'b0;
    run_tmr_d = run_tmr_q;
    unique case (state_q)
      HALT: begin
        run_tmr_d = '0;
        cpu_en_d  = step_press && !run_press;
      end
      RUN: begin
        if (run_press) begin
          run_tmr_d = '0;
        end else if (run_tmr_q == RUN_LAST) begin
          run_tmr_d = '0;
          cpu_en_d  = 1'b1;
        end else begin
          run_tmr_d = run_tmr_q + RUN_W'(1);
        end
      end
      default: run_tmr_d = '0;
    endcase
    step_cnt_d = step_cnt_q + STEP_CNT_W'(cpu_en_q);
  end

  // Manual mode follows ChSel; auto mode restarts its timer on entry and steps on each wrap.
  always_comb begin
    shown_ch_d = shown_ch_q;
    scr_tmr_d  = scr_tmr_q;
    if (!bus.AutoScroll) begin
      shown_ch_d = bus.ChSel;
      scr_tmr_d  = '0;
    end else if (!auto_q) begin
      scr_tmr_d  = '0;
    end else if (scr_tmr_q == SCR_LAST) begin
      scr_tmr_d  = '0;
      shown_ch_d = (shown_ch_q >= CH_LAST) ? '0 : shown_ch_q + CH_W'(1);
    end else begin
      scr_tmr_d  = scr_tmr_q + SCR_W'(1);
    end
  end

  // Out-of-range channel numbers display zero.
  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (shown_ch_q == CH_W'(k)) sel_data = bus.ChData[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      run_tmr_q    <= '0;
      cpu_en_q     <= 1'b0;
      running_q    <= 1'b0;
      step_cnt_q   <= '0;
      scr_tmr_q    <= '0;
      auto_q       <= 1'b0;
      shown_ch_q   <= '0;
      shown_data_q <= '0;
    end else begin
      run_tmr_q    <= run_tmr_d;
      cpu_en_q     <= cpu_en_d;
      running_q    <= (state_d == RUN);
      step_cnt_q   <= step_cnt_d;
      scr_tmr_q    <= scr_tmr_d;
      auto_q       <= bus.AutoScroll;
      shown_ch_q   <= shown_ch_d;
      shown_data_q <= sel_data;
    end
  end

  assign bus.CpuEn     = cpu_en_q;
  assign bus.Running   = running_q;
  assign bus.StepCount = step_cnt_q;
  assign bus.ShownCh   = shown_ch_q;
  assign bus.ShownData = shown_data_q;

endmodule

// File: tb/tb_debug_console.sv
// Self-checking bench for debug_console: vector table, directed button/reset sequences and
// random viewer traffic, all compared each cycle against an event-level reference model.
module tb_debug_console;
  import debug_console_pkg::*;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DB     = 4;
  localparam int unsigned RP     = 5;
  localparam int unsigned SP     = 3;
  localparam int          PRESS_LAT = DB + 3;  // drive-to-CpuEn edges for a clean press

  logic Clk = 1'b0;
  logic Reset;

  debug_console_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) bus ();

  debug_console #(
    .WIDTH(WIDTH), .NUM_CH(NUM_CH), .DEBOUNCE_CYCLES(DB),
    .RUN_PERIOD(RP), .SCROLL_PERIOD(SP)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0]  sel;
    logic [63:0] data;
    logic [1:0]  ech;
    logic [15:0] edata;
  } vec_t;

  vec_t vecs[4];

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  bit          checking = 0;

  // Reference model: button effects are scheduled edges; run mode is "pulse every RP edges".
  int          step_at[$];
  int          run_at[$];
  bit          m_run;
  int          m_phase;
  bit          m_cpu;
  logic [15:0] m_cnt;
  int          m_ch;
  logic [15:0] m_data;
  bit          m_auto_prev;
  int          a_start, a_k;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    step_at.delete();
    run_at.delete();
    m_run = 0; m_phase = 0; m_cpu = 0; m_cnt = '0;
    m_ch = 0; m_data = '0; m_auto_prev = 0; a_start = 0; a_k = 0;
  endtask

  task automatic tick();
    bit          r, au, st_e, ru_e;
    logic [1:0]  sel;
    logic [63:0] dat;
    logic [15:0] nd;
    r = Reset; au = bus.AutoScroll; sel = bus.ChSel; dat = bus.ChData;
    @(posedge Clk);
    cyc++;
    if (r) begin
      model_reset();
    end else begin
      st_e = 0; ru_e = 0;
      for (int i = 0; i < step_at.size(); i++)
        if (step_at[i] == cyc) begin st_e = 1; step_at.delete(i); break; end
      for (int i = 0; i < run_at.size(); i++)
        if (run_at[i] == cyc) begin ru_e = 1; run_at.delete(i); break; end
      m_cnt = m_cnt + 16'(m_cpu);
      m_cpu = 0;
      if (!m_run) begin
        if (ru_e) begin m_run = 1; m_phase = 0; end
        else if (st_e) m_cpu = 1;
      end else if (ru_e) begin
        m_run = 0;
      end else begin
        m_phase++;
        if (m_phase % RP == 0) m_cpu = 1;
      end
      nd = dat[m_ch*WIDTH +: WIDTH];
      if (!au) m_ch = int'(sel);
      else if (!m_auto_prev) begin a_start = m_ch; a_k = 0; end
      else begin a_k++; m_ch = (a_start + a_k / SP) % NUM_CH; end
      m_auto_prev = au;
      m_data = nd;
    end
    #1;
    if (checking) begin
      chk("CpuEn",     64'(bus.CpuEn),     64'(m_cpu));
      chk("Running",   64'(bus.Running),   64'(m_run));
      chk("StepCount", 64'(bus.StepCount), 64'(m_cnt));
      chk("ShownCh",   64'(bus.ShownCh),   64'(m_ch));
      chk("ShownData", 64'(bus.ShownData), 64'(m_data));
    end
  endtask

  // Clean press: raw high for 'hold' cycles, then low for 'low' cycles.
  task automatic press(input bit is_step, input bit is_run, input int hold, input int low);
    if (is_step) begin bus.StepBtn = 1'b1; step_at.push_back(cyc + PRESS_LAT); end
    if (is_run)  begin bus.RunBtn  = 1'b1; run_at.push_back(cyc + PRESS_LAT); end
    repeat (hold) tick();
    bus.StepBtn = 1'b0;
    bus.RunBtn  = 1'b0;
    repeat (low) tick();
  endtask

  initial begin
    int          aseq[13];
    logic [15:0] c0;

    vecs[0] = '{sel: 2'd2, data: 64'hDDDD_CCCC_BBBB_AAAA, ech: 2'd2, edata: 16'hCCCC};
    vecs[1] = '{sel: 2'd0, data: 64'hDDDD_CCCC_BBBB_AAAA, ech: 2'd0, edata: 16'hAAAA};
    vecs[2] = '{sel: 2'd3, data: 64'hDDDD_CCCC_BBBB_AAAA, ech: 2'd3, edata: 16'hDDDD};
    vecs[3] = '{sel: 2'd1, data: 64'h1234_5678_9ABC_DEF0, ech: 2'd1, edata: 16'h9ABC};
    aseq = '{2, 2, 2, 3, 3, 3, 0, 0, 0, 1, 1, 1, 2};

    Reset = 1'b1;
    bus.StepBtn = 0; bus.RunBtn = 0; bus.AutoScroll = 0; bus.ChSel = '0; bus.ChData = '0;
    model_reset();
    repeat (3) tick();
    chk("rst CpuEn",     64'(bus.CpuEn),     64'd0);
    chk("rst Running",   64'(bus.Running),   64'd0);
    chk("rst StepCount", 64'(bus.StepCount), 64'd0);
    chk("rst ShownCh",   64'(bus.ShownCh),   64'd0);
    chk("rst ShownData", 64'(bus.ShownData), 64'd0);
    Reset = 1'b0;
    checking = 1;
    repeat (20) tick();

    // Bounce shorter than the debounce window: no step.
    for (int i = 0; i < 4; i++) begin
      bus.StepBtn = ~bus.StepBtn;
      repeat (2) tick();
    end
    repeat (10) tick();
    chk("bounce StepCount", 64'(bus.StepCount), 64'd0);

    // Single steps, with exact pulse timing checked by the model.
    press(1, 0, 10, 10);
    chk("step1 StepCount", 64'(bus.StepCount), 64'd1);
    press(1, 0, 10, 10);
    chk("step2 StepCount", 64'(bus.StepCount), 64'd2);

    // Free run for 4 pulses, then halt.
    press(0, 1, 10, 10);
    repeat (2) tick();
    press(0, 1, 10, 10);
    chk("run Running",   64'(bus.Running),   64'd0);
    chk("run StepCount", 64'(bus.StepCount), 64'd6);

    // Coincident run+step in HALT, ignored step in RUN, then halt.
    press(1, 1, 10, 10);
    chk("both Running", 64'(bus.Running), 64'd1);
    press(1, 0, 10, 10);
    press(0, 1, 10, 10);
    chk("halt2 Running", 64'(bus.Running), 64'd0);

    // Manual channel vectors.
    foreach (vecs[i]) begin
      bus.ChSel = vecs[i].sel;
      bus.ChData = vecs[i].data;
      tick();
      chk("vec ShownCh", 64'(bus.ShownCh), 64'(vecs[i].ech));
      tick();
      chk("vec ShownData", 64'(bus.ShownData), 64'(vecs[i].edata));
    end

    // Auto-scroll from channel 2.
    bus.ChSel = 2'd2;
    bus.ChData = 64'hDDDD_CCCC_BBBB_AAAA;
    repeat (2) tick();
    bus.AutoScroll = 1'b1;
    foreach (aseq[i]) begin
      tick();
      chk("auto ShownCh", 64'(bus.ShownCh), 64'(aseq[i]));
    end
    bus.AutoScroll = 1'b0;
    tick();
    chk("manual return", 64'(bus.ShownCh), 64'd2);

    // Random viewer traffic.
    for (int i = 0; i < 400; i++) begin
      bus.ChData = {$urandom, $urandom};
      bus.ChSel  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) bus.AutoScroll = ~bus.AutoScroll;
      tick();
    end
    bus.AutoScroll = 1'b0;

    // Random-length clean step presses.
    for (int i = 0; i < 6; i++)
      press(1, 0, $urandom_range(5, 12), $urandom_range(8, 14));
    chk("rand steps", 64'(bus.StepCount), 64'(m_cnt));

    // Asynchronous reset in the middle of RUN.
    press(0, 1, 10, 0);
    c0 = bus.StepCount;
    for (int i = 0; i < 60 && bus.StepCount == c0; i++) tick();
    chk("run pulse seen", 64'(bus.StepCount), 64'(c0 + 16'd1));
    #2;
    Reset = 1'b1;
    #1;
    chk("async Running",   64'(bus.Running),   64'd0);
    chk("async StepCount", 64'(bus.StepCount), 64'd0);
    chk("async ShownCh",   64'(bus.ShownCh),   64'd0);
    chk("async CpuEn",     64'(bus.CpuEn),     64'd0);
    model_reset();
    bus.RunBtn = 1'b0;
    repeat (2) tick();
    Reset = 1'b0;
    repeat (15) tick();
    chk("post-reset HALT", 64'(bus.Running), 64'd0);

    // Step button held through reset release.
    Reset = 1'b1;
    bus.StepBtn = 1'b1;
    repeat (2) tick();
    Reset = 1'b0;
    step_at.push_back(cyc + PRESS_LAT);
    repeat (10) tick();
    bus.StepBtn = 1'b0;
    repeat (10) tick();
    chk("held-through-reset", 64'(bus.StepCount), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
